vga_fb_scan_arbiter: RTL and testbench

// - Scan-out sequencer and single-port framebuffer arbiter for the VGA path.
// - Generates 640x480@60 timing and fetches pixels from a scaled framebuffer (SCALE x SCALE replication).
// - Shares the framebuffer's one RAM port between display reads (absolute priority) and drawing-engine writes.
// - Sits between the pixel generator and the o_red/o_grn/o_blu/o_hsync/o_vsync pins.

---
 rtl/vga_fb_scan_arbiter_pkg.sv | 22 ++
 rtl/vga_fb_scan_arbiter_if.sv | 33 +++
 rtl/vga_fb_scan_arbiter_timing.sv | 53 +++++
 rtl/vga_fb_scan_arbiter.sv | 123 ++++++++++++
 tb/tb_vga_fb_scan_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_scan_arbiter_pkg.sv
// rtl/vga_fb_scan_arbiter_pkg.sv - VGA 640x480@60 timing constants, framebuffer geometry, pixel type
package vga_fb_scan_arbiter_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_SCALE    = 4;
  localparam int VGA_FB_W     = VGA_H_ACTIVE / VGA_SCALE;
  localparam int VGA_FB_H     = VGA_V_ACTIVE / VGA_SCALE;
  localparam int VGA_ADDR_W   = 15;
  localparam int RGB_W        = 3;
  localparam int CNT_W        = 10;

  typedef logic [RGB_W-1:0] rgb3_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/vga_fb_scan_arbiter_if.sv
// rtl/vga_fb_scan_arbiter_if.sv - draw-engine, RAM-port and video-out signals of the scan arbiter
interface vga_fb_scan_arbiter_if
  import vga_fb_scan_arbiter_pkg::*;
#(
  parameter int ADDR_W = VGA_ADDR_W
) ();
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  rgb3_t             wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  rgb3_t             mem_wdata;
  rgb3_t             mem_rdata;
  logic              hsync;
  logic              vsync;
  logic              blank;
  rgb3_t             rgb;
  logic              vblank;
  logic              frame_start;

  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_we, mem_wdata,
    output hsync, vsync, blank, rgb, vblank, frame_start
  );

  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_we, mem_wdata,
    input  hsync, vsync, blank, rgb, vblank, frame_start
  );
endinterface

// File: rtl/vga_fb_scan_arbiter_timing.sv
// rtl/vga_fb_scan_arbiter_timing.sv - h/v scan counters with raw sync, blank and frame markers
module vga_fb_scan_arbiter_timing
  import vga_fb_scan_arbiter_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic clk,
  input  logic rst,
  output cnt_t h,
  output cnt_t v,
  output logic active,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic vblank,
  output logic frame_start,
  output logic frame_end
);
  localparam cnt_t H_LAST = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_ACT  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT  = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + cnt_t'(1);
    end else begin
      h <= h + cnt_t'(1);
    end
  end

  assign active      = (h < H_ACT) && (v < V_ACT);
  assign hsync_raw   = !((h >= HS_BEG) && (h < HS_END));
  assign vsync_raw   = !((v >= VS_BEG) && (v < VS_END));
  assign vblank      = (v >= V_ACT);
  // Gated by reset so the first pulse lands in the cycle right after release.
  assign frame_start = !rst && (h == '0) && (v == '0);
  assign frame_end   = (h == H_LAST) && (v == V_LAST);
endmodule

// File: rtl/vga_fb_scan_arbiter.sv
// rtl/vga_fb_scan_arbiter.sv - VGA scan-out sequencer sharing one framebuffer RAM port with draw writes
module vga_fb_scan_arbiter
  import vga_fb_scan_arbiter_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int SCALE    = VGA_SCALE,
  parameter int ADDR_W   = VGA_ADDR_W
) (
  input logic                  clk,
  input logic                  rst,
  vga_fb_scan_arbiter_if.slave bus
);
  localparam int                FB_W       = H_ACTIVE / SCALE;
  localparam int                FB_H       = V_ACTIVE / SCALE;
  localparam logic [ADDR_W-1:0] FB_WORDS   = ADDR_W'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] FB_W_A     = ADDR_W'(FB_W);
  localparam cnt_t              SCALE_C    = cnt_t'(SCALE);
  localparam cnt_t              SCALE_LAST = cnt_t'(SCALE - 1);
  localparam cnt_t              H_ACT_LAST = cnt_t'(H_ACTIVE - 1);

  cnt_t              h;
  cnt_t              v;
  logic              active;
  logic              hsync_raw;
  logic              vsync_raw;
  logic              frame_end;
  logic              fetch_slot;
  logic              fetch_d1;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] col;
  rgb3_t             pix_reg;
  logic [1:0]        hsync_pipe;
  logic [1:0]        vsync_pipe;
  logic [1:0]        blank_pipe;

  vga_fb_scan_arbiter_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .h           (h),
    .v           (v),
    .active      (active),
    .hsync_raw   (hsync_raw),
    .vsync_raw   (vsync_raw),
    .vblank      (bus.vblank),
    .frame_start (bus.frame_start),
    .frame_end   (frame_end)
  );

  assign fetch_slot = active && ((h % SCALE_C) == '0);

  // Row base advances only after the last replicated line of a framebuffer row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_base <= '0;
      col       <= '0;
    end else if (frame_end) begin
      line_base <= '0;
      col       <= '0;
    end else if (active && (h == H_ACT_LAST)) begin
      col <= '0;
      if ((v % SCALE_C) == SCALE_LAST) begin
        line_base <= line_base + FB_W_A;
      end
    end else if (fetch_slot) begin
      col <= col + 1'b1;
    end
  end

  // Display reads own the port in fetch slots; any other cycle may carry one write.
  always_comb begin
    bus.wr_ack    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.mem_addr  = line_base + col;
    if (!fetch_slot && bus.wr_req) begin
      bus.wr_ack   = 1'b1;
      bus.mem_addr = bus.wr_addr;
      if (bus.wr_addr < FB_WORDS) begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_d1   <= 1'b0;
      pix_reg    <= '0;
      hsync_pipe <= 2'b11;
      vsync_pipe <= 2'b11;
      blank_pipe <= 2'b11;
    end else begin
      fetch_d1   <= fetch_slot;
      if (fetch_d1) begin
        pix_reg <= bus.mem_rdata;
      end
      hsync_pipe <= {hsync_pipe[0], hsync_raw};
      vsync_pipe <= {vsync_pipe[0], vsync_raw};
      blank_pipe <= {blank_pipe[0], !active};
    end
  end

  assign bus.hsync = hsync_pipe[1];
  assign bus.vsync = vsync_pipe[1];
  assign bus.blank = blank_pipe[1];
  assign bus.rgb   = blank_pipe[1] ? '0 : pix_reg;
endmodule

// File: tb/tb_vga_fb_scan_arbiter.sv
// tb/tb_vga_fb_scan_arbiter.sv - directed vector bench for the VGA scan arbiter (short vertical timing)
module tb_vga_fb_scan_arbiter;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 24;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int FB_WORDS = 640;

  typedef struct {
    int          cyc;
    logic        req;
    logic [14:0] addr;
    logic [2:0]  data;
    logic        ack;
    logic        we;
    logic [14:0] maddr;
    logic        hs;
    logic        vs;
    logic        bl;
    logic [2:0]  rgb;
    logic        fs;
    logic        vb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] ram [0:32767];
  logic [2:0] rdata_q = 3'b000;
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  vec_t       vecs[$];

  vga_fb_scan_arbiter_if #(.ADDR_W(15)) bus ();

  vga_fb_scan_arbiter #(
    .V_ACTIVE (16),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    rdata_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = rdata_q;

  task automatic chk(string name, int c, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, act, exp);
    end
  endtask

  task automatic add(int c, logic rq, int a, int d, logic ack, logic we, int ma,
                     logic hs, logic vs, logic bl, int rgb, logic fs, logic vb);
    vec_t e;
    e.cyc = c; e.req = rq; e.addr = 15'(a); e.data = 3'(d);
    e.ack = ack; e.we = we; e.maddr = 15'(ma);
    e.hs = hs; e.vs = vs; e.bl = bl; e.rgb = 3'(rgb); e.fs = fs; e.vb = vb;
    vecs.push_back(e);
  endtask

  task automatic goto(int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
      bus.wr_req = 1'b0;
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ack"},   cyc, 32'(bus.wr_ack),      32'd0);
    chk({tag, "_we"},    cyc, 32'(bus.mem_we),      32'd0);
    chk({tag, "_maddr"}, cyc, 32'(bus.mem_addr),    32'd0);
    chk({tag, "_hs"},    cyc, 32'(bus.hsync),       32'd1);
    chk({tag, "_vs"},    cyc, 32'(bus.vsync),       32'd1);
    chk({tag, "_blank"}, cyc, 32'(bus.blank),       32'd1);
    chk({tag, "_rgb"},   cyc, 32'(bus.rgb),         32'd0);
    chk({tag, "_fs"},    cyc, 32'(bus.frame_start), 32'd0);
    chk({tag, "_vb"},    cyc, 32'(bus.vblank),      32'd0);
  endtask

  initial begin
    int act_acks;
    int blank_acks;
    bit seen;

    for (int i = 0; i < 32768; i++) ram[i] = 3'b000;
    ram[0] = 3'b100; ram[1] = 3'b010; ram[2] = 3'b111;
    ram[159] = 3'b011; ram[160] = 3'b001; ram[640] = 3'b101;

    //   cyc    rq addr d  ack we maddr hs vs bl rgb fs vb
    add(0,      0, 0,   0, 0, 0, 0,   1, 1, 1, 0, 1, 0);
    add(1,      0, 0,   0, 0, 0, 1,   1, 1, 1, 0, 0, 0);
    add(2,      0, 0,   0, 0, 0, 1,   1, 1, 0, 4, 0, 0);
    add(5,      0, 0,   0, 0, 0, 2,   1, 1, 0, 4, 0, 0);
    add(6,      0, 0,   0, 0, 0, 2,   1, 1, 0, 2, 0, 0);
    add(9,      0, 0,   0, 0, 0, 3,   1, 1, 0, 2, 0, 0);
    add(10,     0, 0,   0, 0, 0, 3,   1, 1, 0, 7, 0, 0);
    add(641,    0, 0,   0, 0, 0, 0,   1, 1, 0, 3, 0, 0);
    add(642,    0, 0,   0, 0, 0, 0,   1, 1, 1, 0, 0, 0);
    add(657,    0, 0,   0, 0, 0, 0,   1, 1, 1, 0, 0, 0);
    add(658,    0, 0,   0, 0, 0, 0,   0, 1, 1, 0, 0, 0);
    add(753,    0, 0,   0, 0, 0, 0,   0, 1, 1, 0, 0, 0);
    add(754,    0, 0,   0, 0, 0, 0,   1, 1, 1, 0, 0, 0);
    add(2402,   0, 0,   0, 0, 0, 1,   1, 1, 0, 4, 0, 0);
    add(3201,   1, 500, 5, 1, 1, 500, 1, 1, 1, 0, 0, 0);
    add(3202,   0, 0,   0, 0, 0, 161, 1, 1, 0, 1, 0, 0);
    add(3204,   1, 501, 6, 0, 0, 161, 1, 1, 0, 1, 0, 0);
    add(3205,   1, 640, 7, 1, 0, 640, 1, 1, 0, 1, 0, 0);
    add(3206,   1, 639, 2, 1, 1, 639, 1, 1, 0, 0, 0, 0);
    add(3980,   1, 7,   3, 1, 1, 7,   1, 1, 1, 0, 0, 0);
    add(9682,   0, 0,   0, 0, 0, 501, 1, 1, 0, 5, 0, 0);
    add(12638,  0, 0,   0, 0, 0, 640, 1, 1, 0, 2, 0, 0);
    add(12800,  0, 0,   0, 0, 0, 640, 1, 1, 1, 0, 0, 1);
    add(14401,  0, 0,   0, 0, 0, 640, 1, 1, 1, 0, 0, 1);
    add(14402,  0, 0,   0, 0, 0, 640, 1, 0, 1, 0, 0, 1);
    add(16001,  0, 0,   0, 0, 0, 640, 1, 0, 1, 0, 0, 1);
    add(16002,  0, 0,   0, 0, 0, 640, 1, 1, 1, 0, 0, 1);
    add(19199,  0, 0,   0, 0, 0, 640, 1, 1, 1, 0, 0, 1);
    add(19200,  0, 0,   0, 0, 0, 0,   1, 1, 1, 0, 1, 0);
    add(19230,  0, 0,   0, 0, 0, 8,   1, 1, 0, 3, 0, 0);

    // Reset with a pending request: nothing acknowledged, outputs at rest.
    bus.wr_req = 1'b1; bus.wr_addr = 15'd33; bus.wr_data = 3'b111;
    repeat (3) @(negedge clk);
    #1 chk_reset("rst0");
    @(negedge clk);
    rst = 1'b0;
    bus.wr_req = 1'b0;
    cyc = 0;

    foreach (vecs[i]) begin
      goto(vecs[i].cyc);
      bus.wr_req  = vecs[i].req;
      bus.wr_addr = vecs[i].addr;
      bus.wr_data = vecs[i].data;
      #1;
      chk("ack",   cyc, 32'(bus.wr_ack),      32'(vecs[i].ack));
      chk("we",    cyc, 32'(bus.mem_we),      32'(vecs[i].we));
      chk("maddr", cyc, 32'(bus.mem_addr),    32'(vecs[i].maddr));
      chk("hsync", cyc, 32'(bus.hsync),       32'(vecs[i].hs));
      chk("vsync", cyc, 32'(bus.vsync),       32'(vecs[i].vs));
      chk("blank", cyc, 32'(bus.blank),       32'(vecs[i].bl));
      chk("rgb",   cyc, 32'(bus.rgb),         32'(vecs[i].rgb));
      chk("fs",    cyc, 32'(bus.frame_start), 32'(vecs[i].fs));
      chk("vb",    cyc, 32'(bus.vblank),      32'(vecs[i].vb));
    end

    // Request held across a fetch slot: stalled at h=0, accepted at h=1.
    goto(FRAME + H_TOTAL);
    bus.wr_req = 1'b1; bus.wr_addr = 15'd600; bus.wr_data = 3'b110;
    #1;
    chk("stall_ack", cyc, 32'(bus.wr_ack), 32'd0);
    chk("stall_we",  cyc, 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    cyc++;
    #1;
    chk("held_ack",   cyc, 32'(bus.wr_ack),    32'd1);
    chk("held_we",    cyc, 32'(bus.mem_we),    32'd1);
    chk("held_maddr", cyc, 32'(bus.mem_addr),  32'd600);
    chk("held_wdata", cyc, 32'(bus.mem_wdata), 32'd6);

    // Continuous requests across a whole active line.
    goto(FRAME + 2 * H_TOTAL);
    bus.wr_req = 1'b1; bus.wr_addr = 15'd601; bus.wr_data = 3'b001;
    act_acks = 0;
    blank_acks = 0;
    for (int hh = 0; hh < H_TOTAL; hh++) begin
      if (hh > 0) begin
        @(negedge clk);
        cyc++;
      end
      #1;
      if (bus.wr_ack) begin
        if (hh < 640) act_acks++;
        else blank_acks++;
      end
    end
    bus.wr_req = 1'b0;
    chk("acks_active", cyc, 32'(act_acks),   32'd480);
    chk("acks_hblank", cyc, 32'(blank_acks), 32'd160);

    chk("ram_dropped", cyc, 32'(ram[FB_WORDS]), 32'd5);
    chk("ram_500",     cyc, 32'(ram[500]),      32'd5);
    chk("ram_600",     cyc, 32'(ram[600]),      32'd6);

    // Next frame_start must land exactly two frames after release.
    seen = 1'b0;
    for (int k = 0; k < FRAME + 100; k++) begin
      @(negedge clk);
      cyc++;
      bus.wr_req = 1'b0;
      #1;
      if (bus.frame_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("frame_seen",   cyc, 32'(seen), 32'd1);
    chk("frame_period", cyc, 32'(cyc),  32'(2 * FRAME));

    // Mid-frame reset at v=8, h=300 with a write pending.
    goto(2 * FRAME + 8 * H_TOTAL + 300);
    rst = 1'b1;
    bus.wr_req = 1'b1; bus.wr_addr = 15'd20; bus.wr_data = 3'b011;
    #1 chk_reset("mid_rst0");
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      #1 chk_reset($sformatf("mid_rst%0d", k));
    end
    @(negedge clk);
    rst = 1'b0;
    bus.wr_req = 1'b0;
    cyc = 0;
    #1;
    chk("rel_fs",    cyc, 32'(bus.frame_start), 32'd1);
    chk("rel_maddr", cyc, 32'(bus.mem_addr),    32'd0);
    chk("rel_blank", cyc, 32'(bus.blank),       32'd1);
    @(negedge clk);
    cyc++;
    #1;
    chk("rel_fs1",    cyc, 32'(bus.frame_start), 32'd0);
    chk("rel_maddr1", cyc, 32'(bus.mem_addr),    32'd1);
    chk("ram_20",     cyc, 32'(ram[20]),         32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
